// File: rtl/word_memory.sv
// rtl/word_memory.sv - single-port synchronous word memory with byte lanes and clear engine
module word_memory #(
    parameter int                      DATA_WIDTH  = 16,
    parameter int                      ADDR_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0]   CLEAR_VALUE = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      writeEnable,
    input  logic                      readEnable,
    input  logic [DATA_WIDTH/8-1:0]   byteEnable,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic [DATA_WIDTH-1:0]     dataIn,
    output logic [DATA_WIDTH-1:0]     dataOut,
    output logic                      dataValid,
    input  logic                      clearReq,
    output logic                      ready
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_IDLE  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_clear_addr;
    logic [DATA_WIDTH-1:0]   r_data_out;
    logic                    r_data_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic                    w_access;
    logic                    w_write;
    logic [DATA_WIDTH-1:0]   w_merged;

    assign w_access = (r_state == S_IDLE) && (writeEnable || readEnable);
    assign w_write  = (r_state == S_IDLE) && writeEnable;

    // Write-first: the returned word already carries the newly written lanes.
    always_comb begin
        w_merged = r_mem[address];
        for (int i = 0; i < LANES; i++) begin
            if (writeEnable && byteEnable[i]) begin
                w_merged[8*i +: 8] = dataIn[8*i +: 8];
            end
        end
    end

    // Array has no reset; the clear sweep is what initialises it.
    always_ff @(posedge clock) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_clear_addr] <= CLEAR_VALUE;
        end else if (w_write) begin
            r_mem[address] <= w_merged;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_CLEAR;
            r_clear_addr <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_data_valid <= w_access;
            if (w_access) begin
                r_data_out <= w_merged;
            end
            case (r_state)
                S_CLEAR: begin
                    r_clear_addr <= r_clear_addr + ADDR_WIDTH'(1);
                    if (&r_clear_addr) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (clearReq) begin
                        r_state      <= S_CLEAR;
                        r_clear_addr <= '0;
                        r_ready      <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign dataOut   = r_data_out;
    assign dataValid = r_data_valid;
    assign ready     = r_ready;

endmodule

// File: doc/word_memory.md
Name: word_memory

Overview:
- Parametrised single-port synchronous data memory. Successor to the combinational 16-bit memory.
- Features: registered read, per-byte write lanes, and a hardware clear engine that zeroes the array after reset or on request.
- Sits between the CPU datapath (address/data buses) and the rest of the core.
- Exposes a ready flag so the control unit stalls while the array is being cleared.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words.
- CLEAR_VALUE, 0, word value written to every location by the clear engine.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- writeEnable  input  1  write request this cycle.
- readEnable  input  1  read request this cycle.
- byteEnable  input  DATA_WIDTH/8  write lane mask; bit i covers dataIn[8i+7:8i].
- address  input  ADDR_WIDTH  word address.
- dataIn  input  DATA_WIDTH  write data.
- dataOut  output  DATA_WIDTH  registered read/write-back data.
- dataValid  output  1  one-cycle pulse; dataOut holds the result of the access accepted on the previous edge.
- clearReq  input  1  request a full-array clear.
- ready  output  1  high when accesses are accepted (state IDLE).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=CLEAR, clearAddr=0.
  - dataOut=0, dataValid=0, ready=0.
  - Array contents are not reset directly; the clear engine overwrites them.
- State CLEAR:
  - Each edge writes CLEAR_VALUE to mem[clearAddr], then clearAddr+1.
  - On the edge that writes DEPTH-1, go to IDLE; ready=1 from the next cycle.
  - Total DEPTH cycles from reset release to ready=1.
  - writeEnable, readEnable and clearReq are ignored; no dataValid.
  - clearReq does not restart the sweep.
- State IDLE, ready=1; access accepted when writeEnable|readEnable is high at the edge.
- Write:
  - For each lane i with byteEnable[i]=1, mem[address] lane i <= dataIn lane i; other lanes keep their contents.
  - byteEnable=0 with writeEnable=1 leaves memory unchanged but still counts as an accepted access.
- Read:
  - dataOut <= mem[address] on the accepting edge; dataValid=1 for the following cycle.
  - Latency is one cycle.
- Write with or without read (write-first):
  - dataOut <= merged word (new lanes from dataIn, old lanes from memory).
  - dataValid=1 next cycle.
- No accepted access: dataValid=0 next cycle; dataOut holds its last value.
- clearReq=1 in IDLE:
  - Next state CLEAR, clearAddr=0, ready=0 next cycle.
  - A simultaneous access in the same cycle is still performed, before the clear.
- Back-to-back accesses every cycle are supported; no bubbles in IDLE.
- Reset asserted mid-clear or mid-access aborts the operation and restarts the full clear sweep after release.
- address wraps naturally; every ADDR_WIDTH value is a valid location.

Test Plan:
- Release reset, hold readEnable=1 -> ready=0 and dataValid=0 for exactly 256 cycles (defaults), then ready=1. Read addr 0x01 returns 0x0000 one cycle later with dataValid=1.
- Write 0xAB99 to 0x01 (byteEnable=2'b11), then read 0x01 -> dataOut=0xAB99. The write cycle itself also returns 0xAB99 with dataValid=1.
- Mem[0x10]=0x1234; write 0xFFEE with byteEnable=2'b01 -> read returns 0x12EE. Write 0x5500 with byteEnable=2'b10 -> read returns 0x55EE.
- Back-to-back: writes to 0x20..0x23 on consecutive cycles, then reads 0x20..0x23 on consecutive cycles -> dataValid stays high for 4 cycles and data matches in order.
- Pulse clearReq with a simultaneous write of 0x7777 to 0x05 -> ready low for 256 cycles; afterwards 0x05 and 0x01 read 0x0000.
- Assert reset at clear cycle 100 for one cycle -> ready stays low for a full 256 cycles after release. dataOut=0 and dataValid=0 during reset.
